mouse_packet_tracker: RTL and testbench
=======================================

// Module: mouse_packet_tracker
// PURPOSE
//  Consumes the PS/2 byte stream from MousePS2_Controller (received_data/_en) and frames it into
//  3-byte standard mouse packets. Sign-extends the deltas and integrates them into a cursor
//  position clamped to the 320x240 VGA frame. Produces button levels and a one-cycle left-click
//  pulse for the reaction-time game logic.
// PARAMETERS
//  X_MAX          319        max x coordinate (inclusive)
//  Y_MAX          239        max y coordinate (inclusive)
//  X_INIT         160        x after reset
//  Y_INIT         120        y after reset
//  Y_INVERT       1          1: screen_y -= dy (PS/2 +y is up); 0: screen_y += dy
//  TIMEOUT_CYCLES 1000000    inter-byte timeout in clocks (20 ms @ 50 MHz); used only with the macro
// PORTS
//  CLOCK_50    in   1   system clock, 50 MHz
//  resetn      in   1   asynchronous active-low reset (board KEY[3])
//  rx_data     in   8   byte from PS/2 controller
//  rx_valid    in   1   1-cycle strobe: rx_data valid
//  x_position  out  9   cursor x, 0..X_MAX
//  y_position  out  8   cursor y, 0..Y_MAX
//  left_held   out  1   left button level from last committed packet
//  right_held  out  1   right button level from last committed packet
//  left_click  out  1   1-cycle pulse on left button 0->1
//  pkt_valid   out  1   1-cycle pulse per committed packet
//  sync_err    out  1   1-cycle pulse: byte discarded or packet aborted
// BEHAVIOUR
//  Reset: x=X_INIT, y=Y_INIT, all other outputs 0, FSM=WAIT_B0, holding regs 0.
//  FSM (advances only on rx_valid):
//    WAIT_B0: rx_data[3]==1 -> store flags, go WAIT_B1. Else discard, sync_err=1, stay.
//    WAIT_B1: store dx low byte, go WAIT_B2.
//    WAIT_B2: store dy low byte, raise commit, go WAIT_B0.
//  Commit is registered: pkt_valid, positions, buttons and left_click all update on the edge
//    after the byte-2 strobe (latency 1 clock). A byte arriving in the commit cycle is accepted
//    normally by the FSM.
//  Deltas are 9-bit two's complement: dx={b0[4],b1}, dy={b0[5],b2}. b0[6] (X ovf) forces dx=0;
//    b0[7] (Y ovf) forces dy=0.
//  Position math: extend to 11-bit signed, add delta (subtract for y if Y_INVERT), clamp
//    <0 -> 0 and >MAX -> MAX. No wrap-around under any input.
//  Buttons: left=b0[0], right=b0[1]. left_click = commit & b0[0] & ~left_held (old value).
//    Held button: no repeated pulses.
//  resetn asserted mid-packet: partial bytes dropped, FSM to WAIT_B0, outputs to reset values.
// CONFIGURATION
//  MOUSE_PKT_TIMEOUT_EN defined: a counter clears on every rx_valid and counts while in
//    WAIT_B1/WAIT_B2. At TIMEOUT_CYCLES-1 the FSM returns to WAIT_B0 with a sync_err pulse and
//    the partial packet is dropped. The counter is idle in WAIT_B0.
//  Not defined: no counter logic. Resync relies only on the bit-3 check in WAIT_B0.
// STRUCTURE
//  Package mouse_pkg: SCREEN_W=320, SCREEN_H=240, FSM state encoding, packet flag bit indices.
//  Sub-module mouse_byte_framer: FSM, timeout, holding regs; emits commit + flags/dx/dy.
//  Top: delta sign/ovf handling, clamp accumulators, button/click regs.
// TESTING
//  1. Reset release -> x=160, y=120, left_held/right_held/left_click/pkt_valid/sync_err=0.
//  2. Bytes 08,05,03 -> pkt_valid pulse 1 clk after 3rd strobe; x=165, y=117.
//  3. Bytes 09,00,00 twice -> left_click pulse once (1st packet only); left_held=1 after both.
//  4. Bytes 18,80,00 x3 from x=160 -> x=32, then 0, then 0 (clamped). Bytes 48,FF,00 -> x unchanged.
//  5. Byte 02 in WAIT_B0 -> sync_err pulse, discarded; then 08,01,00 -> x+1.
//     08,05 then resetn pulse, then 08,01,00 -> x=161.
//  6. MOUSE_PKT_TIMEOUT_EN: 08,05, then idle 1000000 clks -> sync_err pulse; then 08,01,00 -> x+1.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, framer state encoding and packet-flag layout for the PS/2 mouse tracker.
package mouse_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    // Bit positions inside the first (flags) byte of a standard 3-byte packet.
    localparam int BIT_LEFT  = 0;
    localparam int BIT_RIGHT = 1;
    localparam int BIT_SYNC  = 3;
    localparam int BIT_XSIGN = 4;
    localparam int BIT_YSIGN = 5;
    localparam int BIT_XOVF  = 6;
    localparam int BIT_YOVF  = 7;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic right;
        logic left;
    } pkt_flags_t;

    function automatic logic signed [10:0] clamp_pos(input logic signed [10:0] v,
                                                     input int max_v);
        if (v < 0)
            return '0;
        else if (int'(v) > max_v)
            return 11'(max_v);
        else
            return v;
    endfunction

endpackage

// File: rtl/mouse_byte_framer.sv
// Frames the PS/2 byte stream into 3-byte packets; optional inter-byte timeout
// when MOUSE_PKT_TIMEOUT_EN is defined.
//
// state   | meaning
// WAIT_B0 | idle, expecting a flags byte with bit 3 set
// WAIT_B1 | flags held, expecting dx low byte
// WAIT_B2 | dx held, expecting dy low byte (commit on arrival)
module mouse_byte_framer
    import mouse_pkg::*;
`ifdef MOUSE_PKT_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1000000
)
`endif
(
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       commit,
    output pkt_flags_t flags,
    output logic [7:0] dx_lo,
    output logic [7:0] dy_lo,
    output logic       sync_err
);

    frame_state_t state;
    pkt_flags_t   flags_q;
    logic [7:0]   dx_q;
    logic         sync_err_q;

    // dy is consumed straight off the bus so the commit lands one edge after the last strobe.
    assign commit   = rx_valid && (state == WAIT_B2);
    assign flags    = flags_q;
    assign dx_lo    = dx_q;
    assign dy_lo    = rx_data;
    assign sync_err = sync_err_q;

`ifdef MOUSE_PKT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;
`endif

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state      <= WAIT_B0;
            flags_q    <= '0;
            dx_q       <= '0;
            sync_err_q <= 1'b0;
`ifdef MOUSE_PKT_TIMEOUT_EN
            tmr        <= '0;
`endif
        end else begin
            sync_err_q <= 1'b0;
            if (rx_valid) begin
`ifdef MOUSE_PKT_TIMEOUT_EN
                tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                case (state)
                    WAIT_B0: begin
                        if (rx_data[BIT_SYNC]) begin
                            flags_q.left   <= rx_data[BIT_LEFT];
                            flags_q.right  <= rx_data[BIT_RIGHT];
                            flags_q.x_sign <= rx_data[BIT_XSIGN];
                            flags_q.y_sign <= rx_data[BIT_YSIGN];
                            flags_q.x_ovf  <= rx_data[BIT_XOVF];
                            flags_q.y_ovf  <= rx_data[BIT_YOVF];
                            state          <= WAIT_B1;
                        end else begin
                            sync_err_q <= 1'b1;
                        end
                    end
                    WAIT_B1: begin
                        dx_q  <= rx_data;
                        state <= WAIT_B2;
                    end
                    WAIT_B2: state <= WAIT_B0;
                    default: state <= WAIT_B0;
                endcase
            end
`ifdef MOUSE_PKT_TIMEOUT_EN
            else if (state != WAIT_B0) begin
                if (tmr == '0) begin
                    state      <= WAIT_B0;
                    sync_err_q <= 1'b1;
                end else begin
                    tmr <= tmr - 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/mouse_packet_tracker.sv
// PS/2 mouse packet tracker: clamped cursor integration, button levels and left-click pulse.
// Inter-byte timeout is enabled by defining MOUSE_PKT_TIMEOUT_EN.
module mouse_packet_tracker
    import mouse_pkg::*;
#(
    parameter int X_MAX    = SCREEN_W - 1,
    parameter int Y_MAX    = SCREEN_H - 1,
    parameter int X_INIT   = 160,
    parameter int Y_INIT   = 120,
    parameter int Y_INVERT = 1
`ifdef MOUSE_PKT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [8:0] x_position,
    output logic [7:0] y_position,
    output logic       left_held,
    output logic       right_held,
    output logic       left_click,
    output logic       pkt_valid,
    output logic       sync_err
);

    logic       commit;
    pkt_flags_t flags;
    logic [7:0] dx_lo;
    logic [7:0] dy_lo;

`ifdef MOUSE_PKT_TIMEOUT_EN
    mouse_byte_framer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_framer (
`else
    mouse_byte_framer u_framer (
`endif
        .clk_sys  (CLOCK_50),
        .rst_b    (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .commit   (commit),
        .flags    (flags),
        .dx_lo    (dx_lo),
        .dy_lo    (dy_lo),
        .sync_err (sync_err)
    );

    logic signed [10:0] dx, dy, x_sum, y_sum, x_next, y_next;

    // 11-bit signed headroom covers screen coordinate plus any 9-bit delta without wrap.
    always_comb begin
        dx = flags.x_ovf ? '0 : {{3{flags.x_sign}}, dx_lo};
        dy = flags.y_ovf ? '0 : {{3{flags.y_sign}}, dy_lo};
        x_sum = $signed({2'b00, x_position}) + dx;
        if (Y_INVERT != 0)
            y_sum = $signed({3'b000, y_position}) - dy;
        else
            y_sum = $signed({3'b000, y_position}) + dy;
        x_next = clamp_pos(x_sum, X_MAX);
        y_next = clamp_pos(y_sum, Y_MAX);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x_position <= 9'(X_INIT);
            y_position <= 8'(Y_INIT);
            left_held  <= 1'b0;
            right_held <= 1'b0;
            left_click <= 1'b0;
            pkt_valid  <= 1'b0;
        end else begin
            pkt_valid  <= commit;
            left_click <= commit & flags.left & ~left_held;
            if (commit) begin
                x_position <= x_next[8:0];
                y_position <= y_next[7:0];
                left_held  <= flags.left;
                right_held <= flags.right;
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Self-checking bench for mouse_packet_tracker: directed packets plus random byte stream
// against a queue-based packet model.
module tb_mouse_packet_tracker;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [8:0] x_position;
    logic [7:0] y_position;
    logic       left_held, right_held, left_click, pkt_valid, sync_err;

    mouse_packet_tracker dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .x_position (x_position),
        .y_position (y_position),
        .left_held  (left_held),
        .right_held (right_held),
        .left_click (left_click),
        .pkt_valid  (pkt_valid),
        .sync_err   (sync_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           mx, my;
    bit           m_left, m_right;
    bit           e_pkt, e_sync, e_click;
    byte unsigned q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        mx = 160; my = 120;
        m_left = 0; m_right = 0;
        e_pkt = 0; e_sync = 0; e_click = 0;
        q.delete();
    endtask

    task automatic model_byte(input byte unsigned b);
        byte unsigned b0, b1, b2;
        int dxv, dyv;
        e_pkt = 0; e_sync = 0; e_click = 0;
        if (q.size() == 0 && b[3] == 1'b0) begin
            e_sync = 1;
        end else begin
            q.push_back(b);
        end
        if (q.size() == 3) begin
            b0 = q[0]; b1 = q[1]; b2 = q[2];
            dxv = b0[6] ? 0 : int'(b1) - (b0[4] ? 256 : 0);
            dyv = b0[7] ? 0 : int'(b2) - (b0[5] ? 256 : 0);
            mx = clampi(mx + dxv, 319);
            my = clampi(my - dyv, 239);
            e_click = b0[0] && !m_left;
            m_left  = b0[0];
            m_right = b0[1];
            e_pkt   = 1;
            q.delete();
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pkt_valid"},  pkt_valid,  e_pkt);
        check({tag, "_sync_err"},   sync_err,   e_sync);
        check({tag, "_left_click"}, left_click, e_click);
        check({tag, "_x"},          x_position, mx);
        check({tag, "_y"},          y_position, my);
        check({tag, "_left_held"},  left_held,  m_left);
        check({tag, "_right_held"}, right_held, m_right);
    endtask

    task automatic send(input string tag, input byte unsigned b);
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b);
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) @(negedge CLOCK_50);
        e_pkt = 0; e_sync = 0; e_click = 0;
        check_all(tag);
    endtask

    task automatic send_pkt(input string tag, input byte unsigned a, input byte unsigned b,
                            input byte unsigned c);
        send(tag, a);
        send(tag, b);
        send(tag, c);
    endtask

    initial begin
        byte unsigned rb;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check_all("in_reset");
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check_all("reset_release");
        check("reset_x_const", x_position, 160);
        check("reset_y_const", y_position, 120);

        send_pkt("basic", 8'h08, 8'h05, 8'h03);
        check("basic_x_const", x_position, 165);
        check("basic_y_const", y_position, 117);
        idle("basic_after", 1);

        send_pkt("click1", 8'h09, 8'h00, 8'h00);
        check("click1_pulse", left_click, 1);
        send_pkt("click2", 8'h09, 8'h00, 8'h00);
        check("click2_no_pulse", left_click, 0);
        check("click2_held", left_held, 1);
        idle("click_after", 1);

        resetn = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        idle("rst2", 1);
        send_pkt("neg1", 8'h18, 8'h80, 8'h00);
        check("neg1_x_const", x_position, 32);
        send_pkt("neg2", 8'h18, 8'h80, 8'h00);
        check("neg2_x_const", x_position, 0);
        send_pkt("neg3", 8'h18, 8'h80, 8'h00);
        check("neg3_x_const", x_position, 0);
        send_pkt("ovf", 8'h48, 8'hFF, 8'h00);
        check("ovf_x_const", x_position, 0);
        send_pkt("right", 8'h08, 8'h7F, 8'h00);
        send_pkt("right2", 8'h08, 8'h7F, 8'h00);
        send_pkt("right3", 8'h08, 8'h7F, 8'h00);
        check("right_clamp_x", x_position, 319);
        send_pkt("ydown", 8'h28, 8'h00, 8'h00);
        check("ydown_clamp_y", y_position, 239);

        send("resync_bad", 8'h02);
        check("resync_err", sync_err, 1);
        send_pkt("resync_ok", 8'h08, 8'h01, 8'h00);

        send("midrst_b0", 8'h08);
        send("midrst_b1", 8'h05);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        check_all("midrst_hold");
        resetn = 1'b1;
        send_pkt("midrst_pkt", 8'h08, 8'h01, 8'h00);
        check("midrst_x_const", x_position, 161);

`ifdef MOUSE_PKT_TIMEOUT_EN
        begin
            int waited;
            bit seen;
            send("to_b0", 8'h08);
            send("to_b1", 8'h05);
            seen = 0;
            waited = 0;
            while (!seen && waited < 1000100) begin
                @(negedge CLOCK_50);
                waited++;
                if (sync_err) seen = 1;
            end
            check("timeout_seen", seen, 1);
            q.delete();
            idle("timeout_after", 1);
            send_pkt("timeout_pkt", 8'h08, 8'h01, 8'h00);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 7) != 0) rb[3] = 1'b1;
            send("rand", rb);
            if ($urandom_range(0, 3) == 0) idle("rand_gap", $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
